vdma_s2mm_video_tx: RTL and testbench

// - Transmit side of the AXI4-Stream video link: packs a plain pixel-beat stream into
//   AXI4-Stream video frames (tuser = SOF, tlast = EOL) for a VDMA S2MM slave port.
// - Frame geometry is set at runtime; the block aligns to the source's start-of-frame.
// - Sits between the pixel source and the VDMA write channel, in the clock domain of
//   the VDMA stream port.

---
 rtl/vdma_s2mm_video_tx.sv | 181 ++++++++++++++++++
 tb/tb_vdma_s2mm_video_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdma_s2mm_video_tx.sv
`default_nettype none
// ============================================================================
// Module      : vdma_s2mm_video_tx
// Description : Packs a plain pixel-beat stream into AXI4-Stream video frames
//               (tuser = start of frame, tlast = end of line) for a VDMA S2MM
//               slave port. Aligns to the source SOF and uses a frame geometry
//               latched at frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module vdma_s2mm_video_tx #(
    parameter int DATA_WIDTH = 64,
    parameter int X_WIDTH    = 13,
    parameter int Y_WIDTH    = 12
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_areset,
    input  logic                  cfg_enable,
    input  logic [X_WIDTH-1:0]    cfg_x_num,
    input  logic [Y_WIDTH-1:0]    cfg_y_num,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_sof,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] m_axis_s2mm_tdata,
    output logic                  m_axis_s2mm_tvalid,
    input  logic                  m_axis_s2mm_tready,
    output logic                  m_axis_s2mm_tuser,
    output logic                  m_axis_s2mm_tlast,
    output logic                  frame_done,
    output logic                  sof_err
);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_wait_sof = 2'd1;
    localparam logic [1:0] c_st_active   = 2'd2;
    localparam logic [1:0] c_st_done     = 2'd3;

    localparam logic [X_WIDTH-1:0] c_x_one = X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0] c_y_one = Y_WIDTH'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [X_WIDTH-1:0]    r_x_num;
    logic [Y_WIDTH-1:0]    r_y_num;
    logic [X_WIDTH-1:0]    r_x_cnt;
    logic [Y_WIDTH-1:0]    r_y_cnt;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_tuser;
    logic                  r_tlast;
    logic                  r_frame_done;
    logic                  r_sof_err;

    logic w_out_free;
    logic w_in_ready;
    logic w_accept;
    logic w_load;
    logic w_x_last;
    logic w_y_last;
    logic w_frame_last;
    logic w_drained;
    logic w_latch;

    // The output register can take a new beat when empty or emptying this cycle.
    assign w_out_free   = !r_tvalid || m_axis_s2mm_tready;
    assign w_accept     = in_valid && w_in_ready;
    // Beats before the SOF in WAIT_SOF are accepted but never loaded (dropped).
    assign w_load       = w_accept && ((r_state == c_st_active) || in_sof);
    assign w_x_last     = (r_x_cnt == (r_x_num - c_x_one));
    assign w_y_last     = (r_y_cnt == (r_y_num - c_y_one));
    assign w_frame_last = w_load && w_x_last && w_y_last;
    assign w_drained    = (r_state == c_st_done) && w_out_free;
    // Geometry is captured whenever a new frame search begins.
    assign w_latch      = cfg_enable && ((r_state == c_st_idle) || w_drained);

    // State register.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and source handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (cfg_enable) begin
                    w_state_nxt = c_st_wait_sof;
                end
            end
            c_st_wait_sof: begin
                w_in_ready = w_out_free;
                if (w_load) begin
                    w_state_nxt = w_frame_last ? c_st_done : c_st_active;
                end
            end
            c_st_active: begin
                w_in_ready = w_out_free;
                if (w_frame_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                if (w_drained) begin
                    w_state_nxt = cfg_enable ? c_st_wait_sof : c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Frame geometry latch.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_x_num <= '0;
            r_y_num <= '0;
        end else if (w_latch) begin
            r_x_num <= cfg_x_num;
            r_y_num <= cfg_y_num;
        end
    end

    // Beat position within the frame; returns to (0,0) after the last beat.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
        end else if (w_load) begin
            if (w_x_last) begin
                r_x_cnt <= '0;
                r_y_cnt <= w_y_last ? '0 : (r_y_cnt + c_y_one);
            end else begin
                r_x_cnt <= r_x_cnt + c_x_one;
            end
        end
    end

    // Single-stage output register; contents held while stalled.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
        end else if (w_load) begin
            r_tdata  <= in_data;
            r_tvalid <= 1'b1;
            r_tuser  <= (r_state == c_st_wait_sof);
            r_tlast  <= w_x_last;
        end else if (m_axis_s2mm_tready) begin
            r_tvalid <= 1'b0;
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
        end
    end

    // One-cycle status pulses.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_frame_done <= 1'b0;
            r_sof_err    <= 1'b0;
        end else begin
            r_frame_done <= w_drained;
            r_sof_err    <= w_accept && in_sof && (r_state == c_st_active);
        end
    end

    assign in_ready           = w_in_ready;
    assign m_axis_s2mm_tdata  = r_tdata;
    assign m_axis_s2mm_tvalid = r_tvalid;
    assign m_axis_s2mm_tuser  = r_tuser;
    assign m_axis_s2mm_tlast  = r_tlast;
    assign frame_done         = r_frame_done;
    assign sof_err            = r_sof_err;

endmodule
`default_nettype wire

// File: tb/tb_vdma_s2mm_video_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdma_s2mm_video_tx
// Description : Self-checking bench for vdma_s2mm_video_tx. Random beat data
//               and downstream back-pressure; expected frames are built from
//               the framing rules (tuser on beat 0, tlast every X beats).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdma_s2mm_video_tx;

    localparam int DATA_WIDTH = 64;
    localparam int X_WIDTH    = 13;
    localparam int Y_WIDTH    = 12;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] d;
        logic                  u;
        logic                  l;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cfg_enable = 1'b0;
    logic [X_WIDTH-1:0]    cfg_x_num = '0;
    logic [Y_WIDTH-1:0]    cfg_y_num = '0;
    logic [DATA_WIDTH-1:0] in_data = '0;
    logic                  in_valid = 1'b0;
    logic                  in_sof = 1'b0;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready = 1'b0;
    logic                  tuser;
    logic                  tlast;
    logic                  frame_done;
    logic                  sof_err;

    // Back-pressure mode: 0 = always ready, 1 = toggle, 2 = random.
    int rdy_mode = 0;

    int n_pass  = 0;
    int n_total = 0;

    // Monitor-owned state.
    beat_t out_q[$];
    int    cyc = 0;
    int    last_hs_cyc = 0;
    int    fd_cnt = 0;
    int    fd_bad = 0;
    int    se_cnt = 0;
    int    rdy_cnt = 0;
    int    stable_viol = 0;
    bit    stalled = 0;
    beat_t held;

    vdma_s2mm_video_tx #(
        .DATA_WIDTH(DATA_WIDTH),
        .X_WIDTH   (X_WIDTH),
        .Y_WIDTH   (Y_WIDTH)
    ) dut (
        .s_axis_aclk       (clk),
        .s_axis_areset     (rst),
        .cfg_enable        (cfg_enable),
        .cfg_x_num         (cfg_x_num),
        .cfg_y_num         (cfg_y_num),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_sof            (in_sof),
        .in_ready          (in_ready),
        .m_axis_s2mm_tdata (tdata),
        .m_axis_s2mm_tvalid(tvalid),
        .m_axis_s2mm_tready(tready),
        .m_axis_s2mm_tuser (tuser),
        .m_axis_s2mm_tlast (tlast),
        .frame_done        (frame_done),
        .sof_err           (sof_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Downstream ready pattern, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tready = 1'b1;
            1:       tready = ~tready;
            default: tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Observe both streams mid-cycle, when all handshake signals are settled.
    always @(negedge clk) begin
        beat_t cur;
        cur = {tdata, tuser, tlast};
        if (!rst) begin
            if (tvalid && tready) begin
                out_q.push_back(cur);
                last_hs_cyc = cyc;
            end
            if (stalled && !(tvalid && (cur == held))) stable_viol++;
            stalled = tvalid && !tready;
            held    = cur;
            if (frame_done) begin
                fd_cnt++;
                if (cyc != last_hs_cyc + 1) fd_bad++;
            end
            if (sof_err)  se_cnt++;
            if (in_ready) rdy_cnt++;
        end else begin
            stalled = 0;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DATA_WIDTH-1:0] d, input bit sof);
        int n;
        bit acc;
        if ($urandom_range(0, 3) == 0) tick(1);
        in_data  = d;
        in_valid = 1'b1;
        in_sof   = sof;
        n   = 0;
        acc = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            tick(1);
            n++;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        check("send_accept", 128'(acc), 128'(1));
    endtask

    // Sends one frame of x*y beats and compares the output against the framing rules.
    // After the first beat the config inputs are moved to (nx, ny) for the next frame.
    task automatic run_frame(input string tag, input int x, input int y, input int nx,
                             input int ny, input int err_beat, input int drop_beat,
                             input bit seq);
        int base, fd0, se0, n;
        logic [DATA_WIDTH-1:0] d;
        logic [DATA_WIDTH-1:0] exp_d[$];
        base = out_q.size();
        fd0  = fd_cnt;
        se0  = se_cnt;
        for (int i = 0; i < x * y; i++) begin
            d = seq ? DATA_WIDTH'(i) : {$urandom, $urandom};
            exp_d.push_back(d);
            send_beat(d, (i == 0) || (i == err_beat));
            if (i == 0) begin
                cfg_x_num = X_WIDTH'(nx);
                cfg_y_num = Y_WIDTH'(ny);
            end
            if (i == drop_beat) cfg_enable = 1'b0;
        end
        n = 0;
        while (fd_cnt == fd0 && n < 300) begin
            tick(1);
            n++;
        end
        check({tag, ".frame_done"}, 128'(fd_cnt - fd0), 128'(1));
        check({tag, ".beats"}, 128'(out_q.size() - base), 128'(x * y));
        for (int i = 0; i < x * y; i++) begin
            if (base + i < out_q.size())
                check($sformatf("%s.beat%0d", tag, i), 128'(out_q[base + i]),
                      128'({exp_d[i], (i == 0), ((i % x) == (x - 1))}));
        end
        check({tag, ".sof_err"}, 128'(se_cnt - se0), 128'((err_beat > 0) ? 1 : 0));
    endtask

    initial begin
        int base, rdy0;
        int xs[3];
        int ys[3];

        // Reset state.
        cfg_x_num = X_WIDTH'(4);
        cfg_y_num = Y_WIDTH'(3);
        tick(3);
        check("reset_outputs", 128'({in_ready, tvalid, tuser, tlast, frame_done, sof_err, tdata}), 128'(0));
        rst = 1'b0;
        tick(3);
        check("idle_outputs", 128'({in_ready, tvalid, tuser, tlast, frame_done, sof_err, tdata}), 128'(0));

        // Basic 4x3 frame, data 0..11, full throughput.
        cfg_enable = 1'b1;
        rdy_mode   = 0;
        run_frame("basic", 4, 3, 4, 3, -1, -1, 1'b1);

        // Same geometry with downstream ready toggling every cycle.
        rdy_mode = 1;
        run_frame("toggle", 4, 3, 4, 3, -1, -1, 1'b0);

        // Non-SOF beats while waiting for SOF are dropped; config change mid-frame deferred.
        rdy_mode = 0;
        tick(2);
        base = out_q.size();
        for (int i = 0; i < 5; i++) send_beat({$urandom, $urandom}, 1'b0);
        tick(3);
        check("drop_pre_sof", 128'(out_q.size() - base), 128'(0));
        run_frame("after_drop", 4, 3, 4, 2, -1, -1, 1'b0);

        // Stray SOF on beat 6 of a 4x2 frame, random back-pressure.
        rdy_mode = 2;
        run_frame("sof_err", 4, 2, 4, 3, 6, -1, 1'b0);

        // Enable drops at beat 5: frame completes, then the block stays idle.
        rdy_mode = 0;
        run_frame("disable", 4, 3, 1, 1, -1, 5, 1'b0);
        rdy0 = rdy_cnt;
        tick(10);
        check("idle_no_ready", 128'(rdy_cnt - rdy0), 128'(0));

        // Single-beat frame, then single-column frames.
        cfg_enable = 1'b1;
        rdy_mode   = 2;
        for (int k = 0; k < 3; k++) begin
            xs[k] = $urandom_range(1, 6);
            ys[k] = $urandom_range(1, 4);
        end
        run_frame("x1y1", 1, 1, 1, 3, -1, -1, 1'b0);
        run_frame("x1y3", 1, 3, xs[0], ys[0], -1, -1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            run_frame($sformatf("rand%0d", k), xs[k], ys[k],
                      (k < 2) ? xs[k + 1] : 4, (k < 2) ? ys[k + 1] : 3, -1, -1, 1'b0);
        end

        // Asynchronous reset in the middle of a frame.
        rdy_mode = 0;
        for (int i = 0; i < 6; i++) send_beat({$urandom, $urandom}, i == 0);
        rst = 1'b1;
        #2;
        check("async_reset", 128'({in_ready, tvalid, tuser, tlast, frame_done, sof_err, tdata}), 128'(0));
        @(negedge clk);
        check("reset_hold", 128'({in_ready, tvalid, tuser, tlast, frame_done, sof_err, tdata}), 128'(0));
        tick(1);
        rst = 1'b0;
        run_frame("post_reset", 4, 3, 4, 3, -1, -1, 1'b0);

        check("stall_stability", 128'(stable_viol), 128'(0));
        check("frame_done_timing", 128'(fd_bad), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
